// File: rtl/lock_sequencer_if.sv
// Signal bundle between PLL top-level control, lock_sequencer and lock_detect.
// The slave modport is the sequencer's view; master is the controller/lock_detect side.
interface lock_sequencer_if;
    logic       enable;
    logic [2:0] coarseThreshold;
    logic [2:0] fineThreshold;
    logic       locked;
    logic       ldDivideEnable;
    logic [2:0] lockThreshold;
    logic       pllReady;
    logic       lockFail;
    logic [2:0] state;
    logic [7:0] lossCount;

    modport master (
        output enable, coarseThreshold, fineThreshold, locked,
        input  ldDivideEnable, lockThreshold, pllReady, lockFail, state, lossCount
    );

    modport slave (
        input  enable, coarseThreshold, fineThreshold, locked,
        output ldDivideEnable, lockThreshold, pllReady, lockFail, state, lossCount
    );
endinterface

// File: rtl/lock_sequencer.sv
// PLL lock-acquisition sequencer: coarse then fine threshold search over lock_detect
// windows, ready/loss tracking with bounded retries before a sticky failure.
module lock_sequencer #(
    parameter int WINDOW_BITS     = 4,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT_WINDOWS = 64,
    parameter int MAX_RETRIES     = 3
) (
    input logic             clock,
    input logic             reset,
    lock_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_COARSE = 3'd2,
        ST_FINE   = 3'd3,
        ST_READY  = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_WINDOWS + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    state_t                   state_r,     state_s;
    state_t                   target_r,    target_s;
    logic [WINDOW_BITS-1:0]   win_cnt_r,   win_cnt_s;
    logic [GOOD_W-1:0]        good_cnt_r,  good_cnt_s;
    logic [TMO_W-1:0]         tmo_cnt_r,   tmo_cnt_s;
    logic [RETRY_W-1:0]       retry_cnt_r, retry_cnt_s;
    logic                     miss_r,      miss_s;
    logic                     ld_en_r,     ld_en_s;
    logic [2:0]               thr_r,       thr_s;
    logic                     ready_r,     ready_s;
    logic                     fail_r,      fail_s;
    logic [7:0]               loss_r,      loss_s;

    logic                     window_end_s;
    logic [GOOD_W-1:0]        good_inc_s;
    logic [TMO_W-1:0]         tmo_inc_s;
    logic [RETRY_W-1:0]       retry_inc_s;

    // Next-state and next-output computation for the sequencer FSM and its counters.
    always_comb begin
        state_s      = state_r;
        target_s     = target_r;
        win_cnt_s    = win_cnt_r;
        good_cnt_s   = good_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        retry_cnt_s  = retry_cnt_r;
        miss_s       = miss_r;
        thr_s        = thr_r;
        loss_s       = loss_r;
        window_end_s = (win_cnt_r == {WINDOW_BITS{1'b1}});
        good_inc_s   = bus.locked ? (good_cnt_r + GOOD_W'(1)) : '0;
        tmo_inc_s    = tmo_cnt_r + TMO_W'(1);
        retry_inc_s  = retry_cnt_r + RETRY_W'(1);

        if (!bus.enable) begin
            state_s     = ST_IDLE;
            target_s    = ST_COARSE;
            win_cnt_s   = '0;
            good_cnt_s  = '0;
            tmo_cnt_s   = '0;
            retry_cnt_s = '0;
            miss_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s     = ST_FLUSH;
                    target_s    = ST_COARSE;
                    retry_cnt_s = '0;
                end
                ST_FLUSH: begin
                    win_cnt_s  = '0;
                    good_cnt_s = '0;
                    tmo_cnt_s  = '0;
                    thr_s      = (target_r == ST_COARSE) ? bus.coarseThreshold : bus.fineThreshold;
                    state_s    = target_r;
                end
                ST_COARSE, ST_FINE: begin
                    win_cnt_s = win_cnt_r + WINDOW_BITS'(1);
                    if (window_end_s) begin
                        good_cnt_s = good_inc_s;
                        tmo_cnt_s  = tmo_inc_s;
                        // Success is tested first so it wins over a coincident timeout.
                        if (good_inc_s == GOOD_W'(LOCK_COUNT)) begin
                            if (state_r == ST_COARSE) begin
                                state_s  = ST_FLUSH;
                                target_s = ST_FINE;
                            end else begin
                                state_s     = ST_READY;
                                retry_cnt_s = '0;
                                miss_s      = 1'b0;
                            end
                        end else if (tmo_inc_s == TMO_W'(TIMEOUT_WINDOWS)) begin
                            retry_cnt_s = retry_inc_s;
                            target_s    = ST_COARSE;
                            state_s     = (retry_inc_s == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_FLUSH;
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_READY: begin
                    win_cnt_s = win_cnt_r + WINDOW_BITS'(1);
                    if (window_end_s) begin
                        if (bus.locked) begin
                            miss_s = 1'b0;
                        end else if (miss_r) begin
                            loss_s      = (loss_r == 8'hFF) ? loss_r : (loss_r + 8'd1);
                            state_s     = ST_FLUSH;
                            target_s    = ST_COARSE;
                            retry_cnt_s = '0;
                            miss_s      = 1'b0;
                        end else begin
                            miss_s = 1'b1;
                        end
                    end else begin
                        miss_s = miss_r;
                    end
                end
                ST_FAIL: begin
                    win_cnt_s = '0;
                    state_s   = ST_FAIL;
                end
                default: begin
                    state_s     = ST_IDLE;
                    win_cnt_s   = '0;
                    good_cnt_s  = '0;
                    tmo_cnt_s   = '0;
                    retry_cnt_s = '0;
                    miss_s      = 1'b0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with the state output.
        ld_en_s = (state_s == ST_COARSE) || (state_s == ST_FINE) || (state_s == ST_READY);
        ready_s = (state_s == ST_READY);
        fail_s  = (state_s == ST_FAIL);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            target_r    <= ST_COARSE;
            win_cnt_r   <= '0;
            good_cnt_r  <= '0;
            tmo_cnt_r   <= '0;
            retry_cnt_r <= '0;
            miss_r      <= 1'b0;
            ld_en_r     <= 1'b0;
            thr_r       <= 3'd0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
            loss_r      <= 8'd0;
        end else begin
            state_r     <= state_s;
            target_r    <= target_s;
            win_cnt_r   <= win_cnt_s;
            good_cnt_r  <= good_cnt_s;
            tmo_cnt_r   <= tmo_cnt_s;
            retry_cnt_r <= retry_cnt_s;
            miss_r      <= miss_s;
            ld_en_r     <= ld_en_s;
            thr_r       <= thr_s;
            ready_r     <= ready_s;
            fail_r      <= fail_s;
            loss_r      <= loss_s;
        end
    end

    assign bus.ldDivideEnable = ld_en_r;
    assign bus.lockThreshold  = thr_r;
    assign bus.pllReady       = ready_r;
    assign bus.lockFail       = fail_r;
    assign bus.state          = state_r;
    assign bus.lossCount      = loss_r;
endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a phase-level reference model queues the expected
// outputs for every clock and an independent monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_lock_sequencer;
    localparam int WINDOW  = 16;
    localparam int LOCKN   = 4;
    localparam int TMO     = 64;
    localparam int RETRIES = 3;

    logic clock = 1'b0;
    logic reset;
    lock_sequencer_if bus ();

    lock_sequencer #(
        .WINDOW_BITS(4), .LOCK_COUNT(LOCKN), .TIMEOUT_WINDOWS(TMO), .MAX_RETRIES(RETRIES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       ld;
        logic [2:0] thr;
        logic       rdy;
        logic       fl;
        logic [7:0] loss;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_thr = 1'b0;

    // Reference model: phase number, clocks spent measuring, and per-rule counters.
    int m_phase = 0, m_target = 2, m_cyc = 0, m_good = 0, m_tmo = 0;
    int m_retries = 0, m_misses = 0, m_loss = 0, m_thr = 0, m_loss_events = 0;

    task automatic model_reset();
        m_phase = 0; m_target = 2; m_cyc = 0; m_good = 0; m_tmo = 0;
        m_retries = 0; m_misses = 0; m_loss = 0; m_thr = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  boundary;
        if (!reset) begin
            model_reset();
            return;
        end
        nxt = m_phase;
        if (!bus.enable) begin
            nxt = 0; m_cyc = 0; m_good = 0; m_tmo = 0; m_retries = 0; m_misses = 0;
        end else begin
            case (m_phase)
                0: begin nxt = 1; m_target = 2; m_retries = 0; end
                1: begin
                    m_thr = (m_target == 2) ? int'(bus.coarseThreshold) : int'(bus.fineThreshold);
                    m_cyc = 0; m_good = 0; m_tmo = 0;
                    nxt = m_target;
                end
                2, 3: begin
                    boundary = ((m_cyc % WINDOW) == WINDOW - 1);
                    m_cyc++;
                    if (boundary) begin
                        m_good = bus.locked ? m_good + 1 : 0;
                        m_tmo++;
                        if (m_good >= LOCKN) begin
                            if (m_phase == 2) begin nxt = 1; m_target = 3; end
                            else begin nxt = 4; m_retries = 0; m_misses = 0; end
                        end else if (m_tmo >= TMO) begin
                            m_retries++;
                            m_target = 2;
                            nxt = (m_retries >= RETRIES) ? 5 : 1;
                        end
                    end
                end
                4: begin
                    boundary = ((m_cyc % WINDOW) == WINDOW - 1);
                    m_cyc++;
                    if (boundary) begin
                        if (bus.locked) m_misses = 0;
                        else begin
                            m_misses++;
                            if (m_misses == 2) begin
                                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                                m_loss_events++;
                                nxt = 1; m_target = 2; m_retries = 0; m_misses = 0;
                            end
                        end
                    end
                end
                5: m_cyc = 0;
                default: nxt = 0;
            endcase
        end
        m_phase = nxt;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st   = 3'(m_phase);
        e.ld   = (m_phase >= 2) && (m_phase <= 4);
        e.thr  = 3'(m_thr);
        e.rdy  = (m_phase == 4);
        e.fl   = (m_phase == 5);
        e.loss = 8'(m_loss);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // lmode: 0 unlocked, 1 locked, 2 alternate per window, 3 unlocked only in READY, 4 random
    task automatic cycle(input int lmode);
        @(negedge clock);
        case (lmode)
            0:       bus.locked = 1'b0;
            1:       bus.locked = 1'b1;
            2:       bus.locked = (((m_cyc / WINDOW) % 2) == 0);
            3:       bus.locked = (m_phase != 4);
            default: bus.locked = ($urandom_range(0, 7) != 0);
        endcase
        if (rand_thr) begin
            bus.coarseThreshold = 3'($urandom_range(0, 7));
            bus.fineThreshold   = 3'($urandom_range(0, 7));
        end
        model_step();
        exp_q.push_back(model_out());
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input int st, input int lmode, input int budget, output int n);
        n = 0;
        while ((int'(bus.state) != st) && (n < budget)) begin
            cycle(lmode);
            n++;
        end
        check($sformatf("reach_state_%0d", st), int'(bus.state), st);
    endtask

    // Monitor: every clock that has a queued expectation is compared against the DUT.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.state, bus.ldDivideEnable, bus.lockThreshold, bus.pllReady,
                     bus.lockFail, bus.lossCount};
                checks++;
                if (a !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL scoreboard @%0t: got st=%0d ld=%0b thr=%0d rdy=%0b fail=%0b loss=%0d, expected st=%0d ld=%0b thr=%0d rdy=%0b fail=%0b loss=%0d",
                                 $time, a.st, a.ld, a.thr, a.rdy, a.fl, a.loss,
                                 e.st, e.ld, e.thr, e.rdy, e.fl, e.loss);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start_events;
        reset = 1'b0;
        bus.enable = 1'b1;
        bus.coarseThreshold = 3'd5;
        bus.fineThreshold   = 3'd1;
        bus.locked = 1'b0;
        #2;
        repeat (2) cycle(1);
        check("reset_state", int'(bus.state), 0);
        check("reset_ld", int'(bus.ldDivideEnable), 0);
        check("reset_thr", int'(bus.lockThreshold), 0);
        check("reset_ready", int'(bus.pllReady), 0);
        check("reset_fail", int'(bus.lockFail), 0);
        check("reset_loss", int'(bus.lossCount), 0);

        reset = 1'b1;
        cycle(1);
        check("flush_state", int'(bus.state), 1);
        check("flush_ld", int'(bus.ldDivideEnable), 0);
        cycle(1);
        check("coarse_state", int'(bus.state), 2);
        check("coarse_ld", int'(bus.ldDivideEnable), 1);
        check("coarse_thr", int'(bus.lockThreshold), 5);

        wait_state(3, 1, 200, n);
        check("coarse_to_fine_cycles", n, 65);
        wait_state(4, 1, 200, n);
        check("fine_to_ready_cycles", n, 64);
        check("ready_thr", int'(bus.lockThreshold), 1);
        check("ready_flag", int'(bus.pllReady), 1);

        repeat (16) cycle(0);
        repeat (32) cycle(1);
        check("single_miss_stays_ready", int'(bus.state), 4);
        repeat (32) cycle(0);
        check("loss_state", int'(bus.state), 1);
        check("loss_count", int'(bus.lossCount), 1);
        check("loss_ready_low", int'(bus.pllReady), 0);
        cycle(0);
        check("loss_reacquire", int'(bus.state), 2);

        wait_state(5, 0, 4000, n);
        check("fail_flag", int'(bus.lockFail), 1);
        check("fail_ld", int'(bus.ldDivideEnable), 0);
        bus.enable = 1'b0;
        cycle(0);
        check("fail_exit_idle", int'(bus.state), 0);
        check("fail_exit_flag", int'(bus.lockFail), 0);

        bus.enable = 1'b1;
        wait_state(3, 1, 200, n);
        repeat (10) cycle(1);
        bus.enable = 1'b0;
        cycle(1);
        check("abort_fine_state", int'(bus.state), 0);
        check("abort_fine_ld", int'(bus.ldDivideEnable), 0);
        bus.enable = 1'b1;
        wait_state(2, 2, 10, n);
        wait_state(1, 2, 1100, n);
        check("toggle_timeout1_cycles", n, 1024);
        wait_state(2, 2, 10, n);
        wait_state(1, 2, 1100, n);
        check("toggle_timeout2_cycles", n, 1024);
        wait_state(2, 2, 10, n);
        wait_state(5, 2, 1100, n);
        check("toggle_timeout3_fail_cycles", n, 1024);
        bus.enable = 1'b0;
        cycle(1);
        bus.enable = 1'b1;

        start_events = m_loss_events;
        n = 0;
        while ((m_loss_events < start_events + 256) && (n < 50000)) begin
            cycle(3);
            n++;
        end
        check("loss_loop_budget", int'(n < 50000), 1);
        check("loss_saturated", int'(bus.lossCount), 255);

        wait_state(2, 1, 10, n);
        repeat (5) cycle(1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_state", int'(bus.state), 0);
        check("async_reset_ld", int'(bus.ldDivideEnable), 0);
        check("async_reset_loss", int'(bus.lossCount), 0);
        cycle(1);
        reset = 1'b1;
        cycle(1);
        check("post_reset_flush", int'(bus.state), 1);

        rand_thr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.enable = ($urandom_range(0, 399) != 0);
            cycle(4);
        end

        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
